// File: rtl/gpio_in_pkg.sv
// Shared definitions for the GPIO input peripheral: register indices and reset values.
package gpio_in_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_STATUS   = 3'd1;
  localparam logic [2:0] ADDR_IRQ_EN   = 3'd2;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
  localparam logic [2:0] ADDR_DEBOUNCE = 3'd5;

  // Every register in the block resets to zero; sliced to the needed width at use.
  localparam logic [31:0] RST_REG      = 32'h0000_0000;
  localparam logic [31:0] RST_DEBOUNCE = 32'h0000_0000;

endpackage

// File: rtl/gpio_in_bus_if.sv
// Peripheral bus shared with the GPIO output block: chip enable, write strobe,
// 3-bit register index, 32-bit write data and combinational read data.
interface gpio_in_bus_if;
  logic        ce;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output ce, output we, output addr, output din, input dout);
  modport slave  (input ce, input we, input addr, input din, output dout);
endinterface

// File: rtl/gpio_in_debounce.sv
// Per-pin debounce filter. With GPIO_IN_DEBOUNCE_EN defined the output only
// follows the synchronized input after it has disagreed for threshold+1
// consecutive cycles; otherwise it is a plain one-cycle register.
module gpio_in_debounce #(
  parameter int DB_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_s2,
  input  logic [DB_W-1:0] i_threshold,
  output logic            o_stable
);

  logic r_stable;

`ifdef GPIO_IN_DEBOUNCE_EN
  logic [DB_W-1:0] r_cnt;

  // Count disagreement cycles; >= keeps the counter bounded if the threshold shrinks mid-count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= {DB_W{1'b0}};
      r_stable <= 1'b0;
    end else if (i_s2 == r_stable) begin
      r_cnt    <= {DB_W{1'b0}};
    end else if (r_cnt >= i_threshold) begin
      r_stable <= i_s2;
      r_cnt    <= {DB_W{1'b0}};
    end else begin
      r_cnt    <= r_cnt + DB_W'(1);
    end
  end
`else
  logic w_unused_threshold;
  assign w_unused_threshold = ^i_threshold;

  // Without debounce the stable state simply follows the synchronizer output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stable <= 1'b0;
    end else begin
      r_stable <= i_s2;
    end
  end
`endif

  assign o_stable = r_stable;

endmodule

// File: rtl/gpio_in_bus.sv
// GPIO input peripheral: 2-FF synchronizer, per-pin debounce, edge detection
// into a sticky W1C status register and a registered, maskable level irq.
// Build option: define GPIO_IN_DEBOUNCE_EN to include the debounce counters and
// the DEBOUNCE register; without it DEBOUNCE reads 0 and latency is fixed at 3.
module gpio_in_bus
  import gpio_in_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DB_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  gpio_in_bus_if.slave     bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             irq
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_status;
  logic [WIDTH-1:0] r_irq_en;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic             r_irq;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [DB_W-1:0]  w_threshold;
  logic             w_wr;
  logic [31:0]      w_rdata;
  logic             w_unused_din;

  assign w_wr         = bus.ce & bus.we;
  assign w_unused_din = ^bus.din;

`ifdef GPIO_IN_DEBOUNCE_EN
  logic [DB_W-1:0] r_debounce;
  assign w_threshold = r_debounce;
`else
  assign w_threshold = {DB_W{1'b0}};
`endif

  // Two-stage synchronizer for the asynchronous pins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= RST_REG[WIDTH-1:0];
      r_s2 <= RST_REG[WIDTH-1:0];
    end else begin
      r_s1 <= gpio_in;
      r_s2 <= r_s1;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
    gpio_in_debounce #(.DB_W(DB_W)) u_db (
      .clk         (clk),
      .rst         (rst),
      .i_s2        (r_s2[gi]),
      .i_threshold (w_threshold),
      .o_stable    (w_stable[gi])
    );
  end

  // Enabled transitions of the debounced state; set beats a same-cycle clear
  assign w_edge = (w_stable & ~r_prev & r_rise_en) | (~w_stable & r_prev & r_fall_en);
  assign w_clr  = (w_wr && (bus.addr == ADDR_STATUS)) ? bus.din[WIDTH-1:0] : {WIDTH{1'b0}};

  // Remember last stable state and accumulate sticky edge flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev   <= RST_REG[WIDTH-1:0];
      r_status <= RST_REG[WIDTH-1:0];
    end else begin
      r_prev   <= w_stable;
      r_status <= (r_status & ~w_clr) | w_edge;
    end
  end

  // Software-writable control registers; DATA and unused indices ignore writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq_en   <= RST_REG[WIDTH-1:0];
      r_rise_en  <= RST_REG[WIDTH-1:0];
      r_fall_en  <= RST_REG[WIDTH-1:0];
`ifdef GPIO_IN_DEBOUNCE_EN
      r_debounce <= RST_DEBOUNCE[DB_W-1:0];
`endif
    end else if (w_wr) begin
      case (bus.addr)
        ADDR_IRQ_EN:   r_irq_en   <= bus.din[WIDTH-1:0];
        ADDR_RISE_EN:  r_rise_en  <= bus.din[WIDTH-1:0];
        ADDR_FALL_EN:  r_fall_en  <= bus.din[WIDTH-1:0];
`ifdef GPIO_IN_DEBOUNCE_EN
        ADDR_DEBOUNCE: r_debounce <= bus.din[DB_W-1:0];
`endif
        default:       r_irq_en   <= r_irq_en;
      endcase
    end
  end

  // Level interrupt, registered one cycle behind STATUS
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_status & r_irq_en);
    end
  end

  assign irq = r_irq;

  // Combinational read mux; zero whenever not a read cycle
  always_comb begin
    w_rdata = 32'h0000_0000;
    if (bus.ce && !bus.we) begin
      case (bus.addr)
        ADDR_DATA:     w_rdata = 32'(w_stable);
        ADDR_STATUS:   w_rdata = 32'(r_status);
        ADDR_IRQ_EN:   w_rdata = 32'(r_irq_en);
        ADDR_RISE_EN:  w_rdata = 32'(r_rise_en);
        ADDR_FALL_EN:  w_rdata = 32'(r_fall_en);
`ifdef GPIO_IN_DEBOUNCE_EN
        ADDR_DEBOUNCE: w_rdata = 32'(r_debounce);
`endif
        default:       w_rdata = 32'h0000_0000;
      endcase
    end else begin
      w_rdata = 32'h0000_0000;
    end
  end

  assign bus.dout = w_rdata;

endmodule
